stopwatch_ctrl: RTL and testbench

- Run/pause/clear sequencer around two `flex_counter` instances.
  - Prescaler instance: produces a one-cycle tick every PRESCALE clocks.
  - Count instance: advances `count_out` on each tick, up to TERMINAL.
- Takes two synchronized pushbutton levels and drives the 4-bit value feeding `hex_display` on the board top level.

---
 rtl/stopwatch_pkg.sv | 19 +
 rtl/flex_counter.sv | 48 ++++
 rtl/stopwatch_ctrl.sv | 119 +++++++++++
 tb/tb_stopwatch_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// ------------------------------------------------------------------
// stopwatch_pkg: shared state encoding and widths. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } stopwatch_state_t;

  localparam int PRESCALE_BITS = 16;

endpackage

`default_nettype wire

// File: rtl/flex_counter.sv
// ------------------------------------------------------------------
// flex_counter: clearable up-counter that rolls over to 1 after rollover_val. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] next_count;
  logic                    next_flag;

  always_comb begin
    next_count = count_out;
    if (clear) begin
      next_count = '0;
    end else if (count_enable) begin
      if (count_out == rollover_val) begin
        next_count = NUM_CNT_BITS'(1);
      end else begin
        next_count = count_out + NUM_CNT_BITS'(1);
      end
    end
    // Registered flag tracks the count, so it stays high while the count sits at rollover_val.
    next_flag = (next_count == rollover_val);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out     <= '0;
      rollover_flag <= 1'b0;
    end else begin
      count_out     <= next_count;
      rollover_flag <= next_flag;
    end
  end

endmodule

`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
// ------------------------------------------------------------------
// stopwatch_ctrl: run/pause/clear sequencer around prescale and count flex_counters. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

import stopwatch_pkg::*;

module stopwatch_ctrl #(
  parameter int NUM_CNT_BITS = 4,
  parameter int PRESCALE     = 4,
  parameter int TERMINAL     = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_btn,
  input  logic                    clear_btn,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    tick,
  output logic                    running,
  output logic                    paused,
  output logic                    done
);

  localparam logic [PRESCALE_BITS-1:0] PRESCALE_VAL = PRESCALE_BITS'(PRESCALE);
  localparam logic [NUM_CNT_BITS-1:0]  TERMINAL_VAL = NUM_CNT_BITS'(TERMINAL);
  localparam logic [NUM_CNT_BITS-1:0]  TERMINAL_M1  = NUM_CNT_BITS'(TERMINAL - 1);

  stopwatch_state_t state, state_next;

  logic                     start_q, clear_q;
  logic                     start_evt, clear_evt;
  logic                     presc_clear;
  logic                     presc_flag;
  logic [PRESCALE_BITS-1:0] presc_cnt_unused;
  logic                     count_flag_unused;

  assign start_evt = start_btn & ~start_q;
  assign clear_evt = clear_btn & ~clear_q;
  assign tick      = presc_flag & (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      start_q <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      state   <= state_next;
      start_q <= start_btn;
      clear_q <= clear_btn;
    end
  end

  always_comb begin
    state_next  = state;
    presc_clear = clear_evt;
    case (state)
      IDLE: begin
        if (!clear_evt && start_evt) begin
          state_next  = RUN;
          presc_clear = 1'b1;
        end
      end
      RUN: begin
        // The terminal tick outranks a pause request landing on the same cycle.
        if (clear_evt) begin
          state_next = IDLE;
        end else if (tick && (count_out == TERMINAL_M1)) begin
          state_next = DONE;
        end else if (start_evt) begin
          state_next = PAUSE;
        end
      end
      PAUSE: begin
        if (clear_evt) begin
          state_next = IDLE;
        end else if (start_evt) begin
          state_next = RUN;
        end
      end
      DONE: begin
        if (clear_evt) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign running = (state == RUN);
  assign paused  = (state == PAUSE);
  assign done    = (state == DONE);

  flex_counter #(
    .NUM_CNT_BITS (PRESCALE_BITS)
  ) u_prescale (
    .clk           (clk),
    .n_rst         (~rst),
    .clear         (presc_clear),
    .count_enable  (state == RUN),
    .rollover_val  (PRESCALE_VAL),
    .count_out     (presc_cnt_unused),
    .rollover_flag (presc_flag)
  );

  flex_counter #(
    .NUM_CNT_BITS (NUM_CNT_BITS)
  ) u_count (
    .clk           (clk),
    .n_rst         (~rst),
    .clear         (clear_evt),
    .count_enable  (tick),
    .rollover_val  (TERMINAL_VAL),
    .count_out     (count_out),
    .rollover_flag (count_flag_unused)
  );

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
// ------------------------------------------------------------------
// tb_stopwatch_ctrl: directed scoreboard bench for stopwatch_ctrl (PRESCALE=4, TERMINAL=9). Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_btn = 1'b0;
  logic       clear_btn = 1'b0;
  logic [3:0] count_out;
  logic       tick, running, paused, done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string name;
    int    cnt;
    bit    tk;
    bit    run;
    bit    pau;
    bit    dn;
  } exp_t;

  exp_t sb_q[$];

  stopwatch_ctrl #(
    .NUM_CNT_BITS (4),
    .PRESCALE     (4),
    .TERMINAL     (9)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_btn (start_btn),
    .clear_btn (clear_btn),
    .count_out (count_out),
    .tick      (tick),
    .running   (running),
    .paused    (paused),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Expected count/tick i cycles after the start press from IDLE (running from i=1).
  function automatic int rcnt(input int i);
    return (i >= 6) ? (i - 2) / 4 : 0;
  endfunction

  function automatic bit rtick(input int i);
    return (i >= 5) && (((i - 5) % 4) == 0);
  endfunction

  task automatic exp(input string nm, input int cnt, input bit tk, input bit run,
                     input bit pau, input bit dn);
    exp_t e;
    e.name = nm; e.cnt = cnt; e.tk = tk; e.run = run; e.pau = pau; e.dn = dn;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic s, input logic c);
    start_btn = s;
    clear_btn = c;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are sampled mid-cycle; one pending expectation per cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      checks++;
      if (int'(count_out) != e.cnt || tick != e.tk || running != e.run ||
          paused != e.pau || done != e.dn) begin
        errors++;
        $display("FAIL %s: got cnt=%0d tick=%0b run=%0b pau=%0b done=%0b, want cnt=%0d tick=%0b run=%0b pau=%0b done=%0b",
                 e.name, count_out, tick, running, paused, done,
                 e.cnt, e.tk, e.run, e.pau, e.dn);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    next();
    exp("reset", 0, 0, 0, 0, 0);
    next();
    rst = 1'b0;
    exp("post_reset_idle", 0, 0, 0, 0, 0);
    next();

    // 1. start, first tick, then async reset mid-cycle
    drive(1, 0); exp("t1_press", 0, 0, 0, 0, 0); next();
    drive(0, 0);
    for (int i = 1; i <= 7; i++) begin
      exp($sformatf("t1_run%0d", i), rcnt(i), rtick(i), 1, 0, 0);
      next();
    end
    rst = 1'b1;
    exp("t1_async_rst", 0, 0, 0, 0, 0);
    next();
    rst = 1'b0;
    exp("t1_after_rst", 0, 0, 0, 0, 0);
    next();

    // 2. full run to DONE, then hold
    drive(1, 0); exp("t2_press", 0, 0, 0, 0, 0); next();
    drive(0, 0);
    for (int i = 1; i <= 37; i++) begin
      exp($sformatf("t2_run%0d", i), rcnt(i), rtick(i), 1, 0, 0);
      next();
    end
    for (int i = 0; i < 20; i++) begin
      exp($sformatf("t2_done%0d", i), 9, 0, 0, 0, 1);
      next();
    end

    // 6. start in DONE is ignored
    drive(1, 0); exp("t6_press", 9, 0, 0, 0, 1); next();
    drive(0, 0);
    for (int i = 0; i < 5; i++) begin
      exp($sformatf("t6_hold%0d", i), 9, 0, 0, 0, 1);
      next();
    end

    // 5b. clear in DONE
    drive(0, 1); exp("t5_clr_done_press", 9, 0, 0, 0, 1); next();
    drive(0, 0); exp("t5_clr_done", 0, 0, 0, 0, 0); next();

    // 3. pause at count 3 and resume
    drive(1, 0); exp("t3_press", 0, 0, 0, 0, 0); next();
    drive(0, 0);
    for (int i = 1; i <= 14; i++) begin
      exp($sformatf("t3_run%0d", i), rcnt(i), rtick(i), 1, 0, 0);
      next();
    end
    drive(1, 0); exp("t3_pause_press", 3, 0, 1, 0, 0); next();
    drive(0, 0);
    for (int i = 0; i < 10; i++) begin
      exp($sformatf("t3_paused%0d", i), 3, 0, 0, 1, 0);
      next();
    end
    drive(1, 0); exp("t3_resume_press", 3, 0, 0, 1, 0); next();
    drive(0, 0);
    exp("t3_resume1", 3, 0, 1, 0, 0); next();
    exp("t3_resume_tick", 3, 1, 1, 0, 0); next();
    exp("t3_resume_cnt4", 4, 0, 1, 0, 0); next();
    drive(0, 1); exp("t3_clr_press", 4, 0, 1, 0, 0); next();
    drive(0, 0); exp("t3_cleared", 0, 0, 0, 0, 0); next();

    // 4. held start button, then 5. simultaneous start+clear at count 5
    for (int i = 0; i <= 14; i++) begin
      drive(1, 0);
      if (i == 0) exp("t4_press", 0, 0, 0, 0, 0);
      else        exp($sformatf("t4_held%0d", i), rcnt(i), rtick(i), 1, 0, 0);
      next();
    end
    drive(0, 0); exp("t4_release", 3, 0, 1, 0, 0); next();
    for (int i = 16; i <= 22; i++) begin
      exp($sformatf("t5_run%0d", i), rcnt(i), rtick(i), 1, 0, 0);
      next();
    end
    drive(1, 1); exp("t5_both_press", 5, 0, 1, 0, 0); next();
    drive(0, 0); exp("t5_clr_prio", 0, 0, 0, 0, 0); next();
    exp("t5_idle_hold", 0, 0, 0, 0, 0); next();

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
